lpddr4_dummy_ctrl: RTL and testbench
====================================

Name: lpddr4_dummy_ctrl

Overview:
- Initiator for the dummy LPDDR4 memory model's command/data pins; translates a simple valid/ready request interface into single-word commands.
- Sits between the SoC bus bridge (AXI side) and the dummy memory.
- Drives the active-low command strobes and the byte address, owns the dq bus during writes, and captures dq on reads.
- Returns a one-cycle response pulse per request and keeps wrapping read/write counters.

Parameters:
- RD_LAT, 1: edges from the memory sampling a read command to the controller capturing dq (1..7).
- TURNAROUND, 1: idle cycles after a read response before the next request is accepted (0..7).
- BANK, 3'd0: constant value driven on mem_ba.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1=write, 0=read.
- req_addr  in  14  byte address.
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte enables, active-high.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  qualifies resp_valid; misaligned address.
- resp_rdata  out  32  read data; held until the next read response.
- mem_cs  out  1  chip select, active-low.
- mem_we  out  1  write enable, active-low (1 = read command).
- mem_ras  out  1  row strobe, active-low.
- mem_cas  out  1  column strobe, active-low.
- mem_addr  out  14  byte address to memory.
- mem_ba  out  3  bank.
- mem_dq  inout  32  data bus, driven only in the write command cycle.
- mem_dm  out  4  data mask = ~req_wstrb during a write, 4'h0 otherwise.
- mem_dqs  out  1  1 during the write command cycle, else 0.
- rd_count  out  16  completed good reads, wrapping.
- wr_count  out  16  completed good writes, wrapping.

Behaviour:
- Reset values:
  - FSM=IDLE; req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_cs/mem_we/mem_ras/mem_cas=1; mem_addr=0; mem_ba=BANK; mem_dm=0; mem_dqs=0.
  - mem_dq released (Z); both counters 0.
- All mem_* outputs are registered; no combinational path from req_* to mem_*.
- States: IDLE, CMD, WAIT, RESP, TURN.
- IDLE:
  - req_ready=1. On req_valid at an edge, latch we/addr/wdata/wstrb and set req_ready=0 until the FSM returns to IDLE.
  - If req_addr[1:0]!=0, go to RESP with err=1 and issue no command.
  - Otherwise go to CMD.
- CMD (exactly one cycle):
  - mem_cs=mem_ras=mem_cas=0, mem_addr=latched address, mem_we=~latched we.
  - Write: additionally drive mem_dq=wdata, mem_dm=~wstrb, mem_dqs=1; next state RESP.
  - Read: next state WAIT.
  - Strobes return to 1 in the following cycle, so the memory sees a single-edge command.
- WAIT:
  - Counter counts RD_LAT cycles; mem_dq released.
  - On the last WAIT edge, capture mem_dq into resp_rdata; next state RESP.
  - With RD_LAT=1: command cycle C, data on bus in C+1, captured at end of C+1.
- RESP (one cycle):
  - resp_valid=1; resp_err set per the latched error.
  - Increment rd_count or wr_count on non-error responses only.
  - Next: TURN if read and TURNAROUND>0, else IDLE.
- TURN: TURNAROUND cycles with req_ready=0, then IDLE. Guarantees the memory has released dq before any write.
- Latencies, accept edge A:
  - Write: command in cycle A+1, resp_valid in A+2, ready again in A+3.
  - Read: command A+1, resp_valid in A+2+RD_LAT.
  - Error: resp_valid in A+1.
- No backpressure on the response; the consumer must accept resp_valid when it is asserted.
- req_valid while req_ready=0 is ignored, not queued.
- resp_rdata is unchanged by write and error responses.
- Counters wrap 16'hFFFF -> 0.
- Reset asserted mid-transaction:
  - Outputs immediately return to reset values; dq is released asynchronously.
  - The pending response is dropped and no partial command is emitted after release.
- mem_dq is never driven in any cycle other than a write CMD cycle.

Test Plan:
- Reset, then read byte address 0x0000 with memory word0=0x00000013 -> one-cycle command pulse (cs/ras/cas=0, we=1, addr=0x0000); resp_valid at A+3; resp_rdata=0x00000013; rd_count=1.
- Write 0xCAFEBABE to 0x0100 with wstrb=4'hF, then read 0x0100 -> write command in A+1 drives dq=0xCAFEBABE, dm=0, dqs=1; read returns 0xCAFEBABE; wr_count=1, rd_count=1.
- Read 0x0004 immediately followed by a held write request -> req_ready stays 0 for exactly TURNAROUND=1 cycle after the read resp_valid; dq undriven by both sides from the read data cycle until the write command cycle.
- Request to addr 0x0102 -> no strobe activity; resp_valid with resp_err=1 at A+1; counters unchanged; resp_rdata keeps its previous value.
- Assert rst during a read WAIT cycle -> strobes=1 and dq=Z in the same cycle; no resp_valid after release; req_ready=1 on the first edge after release.
- Preset rd_count to 16'hFFFF via 65535 reads (or force in simulation), then one more read -> rd_count=0.

Source files
------------

// File: rtl/lpddr4_dummy_ctrl.sv
// Single-word command initiator for the dummy LPDDR4 model: turns a valid/ready
// request into one-cycle strobe commands and returns a one-cycle response.
module lpddr4_dummy_ctrl #(
    parameter int         RD_LAT     = 1,
    parameter int         TURNAROUND = 1,
    parameter logic [2:0] BANK       = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [13:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_cs,
    output logic        mem_we,
    output logic        mem_ras,
    output logic        mem_cas,
    output logic [13:0] mem_addr,
    output logic [2:0]  mem_ba,
    inout  wire  [31:0] mem_dq,
    output logic [3:0]  mem_dm,
    output logic        mem_dqs,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    typedef enum logic [2:0] {IDLE, CMD, WAIT, RESP, TURN} state_t;

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic        we_reg;
    logic        dq_oe_reg;
    logic [31:0] dq_out_reg;

    // The enable is reset asynchronously, so dq is released the instant rst rises.
    assign mem_dq = dq_oe_reg ? dq_out_reg : 32'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 3'd0;
            we_reg     <= 1'b0;
            dq_oe_reg  <= 1'b0;
            dq_out_reg <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_cs     <= 1'b1;
            mem_we     <= 1'b1;
            mem_ras    <= 1'b1;
            mem_cas    <= 1'b1;
            mem_addr   <= 14'd0;
            mem_ba     <= BANK;
            mem_dm     <= 4'h0;
            mem_dqs    <= 1'b0;
            rd_count   <= 16'd0;
            wr_count   <= 16'd0;
        end else begin
            // Strobes and the write data phase only ever last one cycle.
            resp_valid <= 1'b0;
            mem_cs     <= 1'b1;
            mem_we     <= 1'b1;
            mem_ras    <= 1'b1;
            mem_cas    <= 1'b1;
            mem_dm     <= 4'h0;
            mem_dqs    <= 1'b0;
            dq_oe_reg  <= 1'b0;
            mem_ba     <= BANK;

            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_reg    <= req_we;
                        if (req_addr[1:0] != 2'b00) begin
                            state_reg  <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state_reg <= CMD;
                            mem_cs    <= 1'b0;
                            mem_ras   <= 1'b0;
                            mem_cas   <= 1'b0;
                            mem_we    <= ~req_we;
                            mem_addr  <= req_addr;
                            if (req_we) begin
                                dq_oe_reg  <= 1'b1;
                                dq_out_reg <= req_wdata;
                                mem_dm     <= ~req_wstrb;
                                mem_dqs    <= 1'b1;
                            end
                        end
                    end
                end
                CMD: begin
                    if (we_reg) begin
                        state_reg  <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        wr_count   <= wr_count + 16'd1;
                    end else begin
                        state_reg <= WAIT;
                        cnt_reg   <= 3'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    if (cnt_reg == 3'd0) begin
                        state_reg  <= RESP;
                        resp_rdata <= mem_dq;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        rd_count   <= rd_count + 16'd1;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                RESP: begin
                    if (!we_reg && TURNAROUND > 0) begin
                        state_reg <= TURN;
                        cnt_reg   <= 3'(TURNAROUND - 1);
                    end else begin
                        state_reg <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                TURN: begin
                    if (cnt_reg == 3'd0) begin
                        state_reg <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpddr4_dummy_ctrl.sv
// Bench for lpddr4_dummy_ctrl: a tiny word memory on the command pins, a probe
// driver to detect anyone else holding dq, table vectors plus corner sequences.
module tb_lpddr4_dummy_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [13:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_cs, mem_we, mem_ras, mem_cas;
    logic [13:0] mem_addr;
    logic [2:0]  mem_ba;
    wire  [31:0] mem_dq;
    logic [3:0]  mem_dm;
    logic        mem_dqs;
    logic [15:0] rd_count, wr_count;

    logic        mem_oe;
    logic [31:0] mem_out;
    logic        probe_oe = 1'b0;
    logic [31:0] probe_val = 32'hA5C3_5A3C;
    logic [31:0] mem [256];
    int          cmd_count;

    int n_checks = 0;
    int n_fail   = 0;

    assign mem_dq = mem_oe   ? mem_out   : 32'bz;
    assign mem_dq = probe_oe ? probe_val : 32'bz;

    always #5 clk = ~clk;

    lpddr4_dummy_ctrl #(.RD_LAT(1), .TURNAROUND(1), .BANK(3'd0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_ras(mem_ras), .mem_cas(mem_cas),
        .mem_addr(mem_addr), .mem_ba(mem_ba), .mem_dq(mem_dq), .mem_dm(mem_dm),
        .mem_dqs(mem_dqs), .rd_count(rd_count), .wr_count(wr_count)
    );

    // Dummy memory: samples commands on posedge, returns read data the next cycle.
    always @(posedge clk) begin
        if (rst) begin
            mem_oe    <= 1'b0;
            mem_out   <= 32'd0;
            cmd_count <= 0;
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 0) ? 32'h0000_0013 : 32'h1000_0000 + 32'(i);
        end else begin
            mem_oe <= 1'b0;
            if (!mem_cs && !mem_ras && !mem_cas) begin
                cmd_count <= cmd_count + 1;
                if (!mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (!mem_dm[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_dq[b*8 +: 8];
                end else begin
                    mem_oe  <= 1'b1;
                    mem_out <= mem[mem_addr[9:2]];
                end
            end
        end
    end

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        err;
        int          lat;
        logic [31:0] rdata;
        logic [15:0] rdc;
        logic [15:0] wrc;
    } vec_t;

    vec_t vecs [8];
    vec_t roll_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic probe_check(input string name);
        probe_oe = 1'b1;
        #1;
        check(name, mem_dq, probe_val);
        probe_oe = 1'b0;
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int c0;
        logic cs1, we1, dqs1;
        logic [13:0] a1;
        logic [3:0] dm1;
        logic [31:0] dq1;
        wait_ready();
        c0 = cmd_count;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cs1 = mem_cs; we1 = mem_we; dqs1 = mem_dqs; a1 = mem_addr; dm1 = mem_dm; dq1 = mem_dq;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        $display("vec %0d we=%0b addr=%h lat=%0d err=%0b rdata=%h rd=%0d wr=%0d",
                 idx, v.we, v.addr, n, resp_err, resp_rdata, rd_count, wr_count);
        check("resp_latency", 32'(n), 32'(v.lat));
        check("resp_err", {31'd0, resp_err}, {31'd0, v.err});
        check("resp_rdata", resp_rdata, v.rdata);
        check("rd_count", {16'd0, rd_count}, {16'd0, v.rdc});
        check("wr_count", {16'd0, wr_count}, {16'd0, v.wrc});
        if (v.err) begin
            check("err_no_cs", {31'd0, cs1}, 32'd1);
            check("err_no_cmd", 32'(cmd_count - c0), 32'd0);
        end else begin
            check("cmd_cs", {31'd0, cs1}, 32'd0);
            check("cmd_we", {31'd0, we1}, {31'd0, ~v.we});
            check("cmd_addr", {18'd0, a1}, {18'd0, v.addr});
            check("cmd_dqs", {31'd0, dqs1}, {31'd0, v.we});
            check("cmd_dm", {28'd0, dm1}, {28'd0, (v.we ? ~v.wstrb : 4'h0)});
            if (v.we) check("cmd_dq", dq1, v.wdata);
            check("cmd_once", 32'(cmd_count - c0), 32'd1);
        end
    endtask

    task automatic quiet_after_reset(input string tag);
        int seen_resp = 0;
        int seen_cs = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after_release"}, {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) seen_resp++;
            if (!mem_cs) seen_cs++;
            @(negedge clk);
        end
        $display("%s reset: resp_after=%0d cmd_after=%0d rd=%0d wr=%0d", tag, seen_resp, seen_cs, rd_count, wr_count);
        check({tag, "_no_resp"}, 32'(seen_resp), 32'd0);
        check({tag, "_no_cmd"}, 32'(seen_cs), 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
    endtask

    initial begin
        vecs[0] = '{we:1'b0, addr:14'h0000, wdata:32'h0, wstrb:4'h0, err:1'b0, lat:3, rdata:32'h0000_0013, rdc:16'd1, wrc:16'd0};
        vecs[1] = '{we:1'b1, addr:14'h0100, wdata:32'hCAFE_BABE, wstrb:4'hF, err:1'b0, lat:2, rdata:32'h0000_0013, rdc:16'd1, wrc:16'd1};
        vecs[2] = '{we:1'b0, addr:14'h0100, wdata:32'h0, wstrb:4'h0, err:1'b0, lat:3, rdata:32'hCAFE_BABE, rdc:16'd2, wrc:16'd1};
        vecs[3] = '{we:1'b1, addr:14'h0104, wdata:32'h1122_3344, wstrb:4'h5, err:1'b0, lat:2, rdata:32'hCAFE_BABE, rdc:16'd2, wrc:16'd2};
        vecs[4] = '{we:1'b0, addr:14'h0104, wdata:32'h0, wstrb:4'h0, err:1'b0, lat:3, rdata:32'h1022_0044, rdc:16'd3, wrc:16'd2};
        vecs[5] = '{we:1'b1, addr:14'h0102, wdata:32'hFFFF_FFFF, wstrb:4'hF, err:1'b1, lat:1, rdata:32'h1022_0044, rdc:16'd3, wrc:16'd2};
        vecs[6] = '{we:1'b0, addr:14'h0003, wdata:32'h0, wstrb:4'h0, err:1'b1, lat:1, rdata:32'h1022_0044, rdc:16'd3, wrc:16'd2};
        vecs[7] = '{we:1'b0, addr:14'h0008, wdata:32'h0, wstrb:4'h0, err:1'b0, lat:3, rdata:32'h1000_0002, rdc:16'd4, wrc:16'd2};
        roll_vec = '{we:1'b0, addr:14'h0000, wdata:32'h0, wstrb:4'h0, err:1'b0, lat:3, rdata:32'h0000_0013, rdc:16'd0, wrc:16'd0};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 14'd0; req_wdata = 32'd0; req_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_strobes", {28'd0, mem_cs, mem_we, mem_ras, mem_cas}, 32'hF);
        check("rst_addr", {18'd0, mem_addr}, 32'd0);
        check("rst_ba", {29'd0, mem_ba}, 32'd0);
        check("rst_dm_dqs", {27'd0, mem_dm, mem_dqs}, 32'd0);
        check("rst_counts", {rd_count, wr_count}, 32'd0);
        probe_check("rst_dq_released");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Read immediately followed by a held write: turnaround gap and a quiet dq.
        begin
            int n;
            int k;
            wait_ready();
            req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0004;
            @(posedge clk);
            @(negedge clk);
            req_we = 1'b1; req_addr = 14'h0108; req_wdata = 32'h55AA_00FF; req_wstrb = 4'hF;
            n = 1;
            while (!resp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("turn_read_latency", 32'(n), 32'd3);
            check("turn_read_rdata", resp_rdata, 32'h1000_0001);
            probe_check("turn_dq_free_resp");
            k = 0;
            @(negedge clk);
            while (!req_ready && k < 10) begin
                probe_check("turn_dq_free_gap");
                k++;
                @(negedge clk);
            end
            check("turn_gap_cycles", 32'(k), 32'd1);
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            check("turn_wr_cs", {31'd0, mem_cs}, 32'd0);
            check("turn_wr_we", {31'd0, mem_we}, 32'd0);
            check("turn_wr_dq", mem_dq, 32'h55AA_00FF);
            @(negedge clk);
            check("turn_wr_resp", {31'd0, resp_valid}, 32'd1);
            check("turn_counts", {rd_count, wr_count}, {16'd5, 16'd3});
            $display("turnaround: read lat=%0d gap=%0d rd=%0d wr=%0d", n, k, rd_count, wr_count);
        end

        // Reset during a write command cycle: strobes and dq must drop at once.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h010C; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("wr_rst_pre_cs", {31'd0, mem_cs}, 32'd0);
        rst = 1'b1;
        #1;
        check("wr_rst_strobes", {28'd0, mem_cs, mem_we, mem_ras, mem_cas}, 32'hF);
        check("wr_rst_dqs", {31'd0, mem_dqs}, 32'd0);
        probe_check("wr_rst_dq_released");
        quiet_after_reset("wr");
        check("wr_rst_wr_count", {16'd0, wr_count}, 32'd0);

        // Reset during a read WAIT cycle: no response may follow release.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rd_rst_strobes", {28'd0, mem_cs, mem_we, mem_ras, mem_cas}, 32'hF);
        check("rd_rst_resp", {31'd0, resp_valid}, 32'd0);
        quiet_after_reset("rd");
        check("rd_rst_rd_count", {16'd0, rd_count}, 32'd0);

        // Read counter wrap.
        @(negedge clk);
        force dut.rd_count = 16'hFFFF;
        #1;
        release dut.rd_count;
        #1;
        check("roll_preset", {16'd0, rd_count}, 32'h0000_FFFF);
        run_vec(roll_vec, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
